// File: rtl/i2c_pkg.sv
// Shared I2C front-end definitions: channel indices, filter defaults and
// recommended filter lengths per bus mode.
package i2c_pkg;

    // Bit positions of the two I2C lines in multi-channel vectors
    localparam int CH_SCL = 0;
    localparam int CH_SDA = 1;

    // Default filter counter width and idle level of the bus
    localparam int   DEF_CNT_W   = 4;
    localparam logic DEF_RST_VAL = 1'b1;

    typedef enum logic [1:0] {
        BUS_STD   = 2'd0,
        BUS_FAST  = 2'd1,
        BUS_FASTP = 2'd2
    } bus_mode_e;

    // Recommended cfg_len for a 100 MHz clock. Fast and fast+ must suppress
    // spikes up to 50 ns. Standard mode has no spike limit, so it uses the
    // longest filter.
    function automatic logic [DEF_CNT_W-1:0] glitch_len_rec(input bus_mode_e mode);
        logic [DEF_CNT_W-1:0] len_s;
        case (mode)
            BUS_STD:   len_s = 4'd15;
            BUS_FAST:  len_s = 4'd5;
            BUS_FASTP: len_s = 4'd5;
            default:   len_s = 4'd15;
        endcase
        return len_s;
    endfunction

endpackage

// File: rtl/deglitch_ch.sv
// One filtered line: synchroniser, run-length counter, accepted-level flop
// and registered rise/fall/glitch strobes.
module deglitch_ch
    import i2c_pkg::*;
#(
    parameter int   SYNC_STG = 2,
    parameter int   CNT_W    = DEF_CNT_W,
    parameter logic RST_VAL  = DEF_RST_VAL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic [CNT_W-1:0] cfg_len,
    input  logic             byp,
    output logic             dout,
    output logic             rise,
    output logic             fall,
    output logic             glitch
);

    logic [SYNC_STG-1:0] sync_r;
    logic                s_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_nxt_s;
    logic                dout_r;
    logic                dout_nxt_s;
    logic                rise_r;
    logic                rise_nxt_s;
    logic                fall_r;
    logic                fall_nxt_s;
    logic                glitch_r;
    logic                glitch_nxt_s;

    // The filter sees only the last synchroniser stage
    assign s_s = sync_r[SYNC_STG-1];

    // Synchroniser shift chain for the asynchronous pad input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STG{RST_VAL}};
        end else begin
            sync_r <= {sync_r[SYNC_STG-2:0], din};
        end
    end

    // Run-length filter decision. The counter saturates at cfg_len because it
    // only increments while it is below cfg_len. If cfg_len shrinks below a
    // running count, the next cycle accepts the new level.
    always_comb begin
        cnt_nxt_s    = cnt_r;
        dout_nxt_s   = dout_r;
        glitch_nxt_s = 1'b0;
        if (byp) begin
            cnt_nxt_s  = {CNT_W{1'b0}};
            dout_nxt_s = s_s;
        end else if (s_s == dout_r) begin
            cnt_nxt_s    = {CNT_W{1'b0}};
            glitch_nxt_s = (cnt_r != {CNT_W{1'b0}});
        end else if (cnt_r >= cfg_len) begin
            cnt_nxt_s  = {CNT_W{1'b0}};
            dout_nxt_s = s_s;
        end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end
        rise_nxt_s = dout_nxt_s & ~dout_r;
        fall_nxt_s = ~dout_nxt_s & dout_r;
    end

    // Counter, accepted level and one-cycle event strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= {CNT_W{1'b0}};
            dout_r   <= RST_VAL;
            rise_r   <= 1'b0;
            fall_r   <= 1'b0;
            glitch_r <= 1'b0;
        end else begin
            cnt_r    <= cnt_nxt_s;
            dout_r   <= dout_nxt_s;
            rise_r   <= rise_nxt_s;
            fall_r   <= fall_nxt_s;
            glitch_r <= glitch_nxt_s;
        end
    end

    assign dout   = dout_r;
    assign rise   = rise_r;
    assign fall   = fall_r;
    assign glitch = glitch_r;

endmodule

// File: rtl/i2c_deglitch_sync.sv
// Clocked deglitcher for the I2C pad inputs. Each line is filtered
// independently. Filter length and bypass are shared across all lines.
// SYNC_STG is intended to be 2 or 3.
module i2c_deglitch_sync
    import i2c_pkg::*;
#(
    parameter int   N_CH     = 2,
    parameter int   SYNC_STG = 2,
    parameter int   CNT_W    = DEF_CNT_W,
    parameter logic RST_VAL  = DEF_RST_VAL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  din,
    input  logic [CNT_W-1:0] cfg_len,
    input  logic             byp,
    output logic [N_CH-1:0]  dout,
    output logic [N_CH-1:0]  rise,
    output logic [N_CH-1:0]  fall,
    output logic [N_CH-1:0]  glitch
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        deglitch_ch #(
            .SYNC_STG (SYNC_STG),
            .CNT_W    (CNT_W),
            .RST_VAL  (RST_VAL)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .din     (din[i]),
            .cfg_len (cfg_len),
            .byp     (byp),
            .dout    (dout[i]),
            .rise    (rise[i]),
            .fall    (fall[i]),
            .glitch  (glitch[i])
        );
    end

endmodule

// File: tb/tb_i2c_deglitch_sync.sv
// Self-checking bench for i2c_deglitch_sync. A cycle model pushes expected
// output words into a scoreboard queue at each rising edge. Each scenario
// task pops the words on the falling edge and compares them with the DUT.
// The tasks also make direct latency and pulse-count checks.
module tb_i2c_deglitch_sync;

    localparam int N_CH     = 2;
    localparam int SYNC_STG = 2;
    localparam int CNT_W    = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N_CH-1:0]  din = 2'b11;
    logic [CNT_W-1:0] cfg_len = 4'd4;
    logic             byp = 1'b0;
    logic [N_CH-1:0]  dout;
    logic [N_CH-1:0]  rise;
    logic [N_CH-1:0]  fall;
    logic [N_CH-1:0]  glitch;

    int vectors = 0;
    int miscompares = 0;

    // Scoreboard word layout: {glitch, fall, rise, dout}
    logic [4*N_CH-1:0] exp_q [$];

    // Reference model state
    logic [SYNC_STG-1:0] m_sync [N_CH];
    int                  m_cnt  [N_CH];
    logic [N_CH-1:0]     m_dout, m_rise, m_fall, m_glitch;

    i2c_deglitch_sync #(
        .N_CH     (N_CH),
        .SYNC_STG (SYNC_STG),
        .CNT_W    (CNT_W),
        .RST_VAL  (1'b1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (din),
        .cfg_len (cfg_len),
        .byp     (byp),
        .dout    (dout),
        .rise    (rise),
        .fall    (fall),
        .glitch  (glitch)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        for (int c = 0; c < N_CH; c++) begin
            logic s;
            s = m_sync[c][SYNC_STG-1];
            m_rise[c]   = 1'b0;
            m_fall[c]   = 1'b0;
            m_glitch[c] = 1'b0;
            if (!rst_n) begin
                m_sync[c] = {SYNC_STG{1'b1}};
                m_dout[c] = 1'b1;
                m_cnt[c]  = 0;
            end else begin
                if (byp) begin
                    if (s != m_dout[c]) begin
                        m_rise[c] = s;
                        m_fall[c] = ~s;
                    end
                    m_dout[c] = s;
                    m_cnt[c]  = 0;
                end else if (s == m_dout[c]) begin
                    m_glitch[c] = (m_cnt[c] != 0);
                    m_cnt[c]    = 0;
                end else if (m_cnt[c] >= int'(cfg_len)) begin
                    m_rise[c] = s;
                    m_fall[c] = ~s;
                    m_dout[c] = s;
                    m_cnt[c]  = 0;
                end else begin
                    m_cnt[c] = m_cnt[c] + 1;
                end
                m_sync[c] = {m_sync[c][SYNC_STG-2:0], din[c]};
            end
        end
    endtask

    // Advances one clock. It returns the observed and expected output words,
    // both sampled on the falling edge.
    task automatic tick(output logic [4*N_CH-1:0] obs, output logic [4*N_CH-1:0] exp);
        @(posedge clk);
        model_step();
        exp_q.push_back({m_glitch, m_fall, m_rise, m_dout});
        @(negedge clk);
        obs = {glitch, fall, rise, dout};
        exp = exp_q.pop_front();
    endtask

    task automatic test_reset();
        logic [7:0] obs, exp;
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            din = 2'(i);
            tick(obs, exp);
            vectors++;
            if (obs !== 8'h03) begin
                miscompares++;
                $display("FAIL reset_state: got %h expected 03", obs);
            end
        end
        din = 2'b11;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(obs, exp);
            vectors++;
            if (obs !== exp || obs[7:2] !== 6'd0) begin
                miscompares++;
                $display("FAIL reset_release: got %h expected %h", obs, exp);
            end
        end
    endtask

    task automatic test_sda_fall();
        logic [7:0] obs, exp;
        int t_fall, n_fall;
        t_fall = -1;
        n_fall = 0;
        cfg_len = 4'd4;
        din = 2'b01;
        for (int t = 1; t <= 20; t++) begin
            tick(obs, exp);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL sda_fall_model: got %h expected %h", obs, exp);
            end
            if (obs[1] == 1'b0 && t_fall < 0) t_fall = t;
            if (obs[5]) n_fall++;
        end
        vectors++;
        if (t_fall != SYNC_STG + 5) begin
            miscompares++;
            $display("FAIL sda_fall_latency: got %0d expected %0d", t_fall, SYNC_STG + 5);
        end
        vectors++;
        if (n_fall != 1) begin
            miscompares++;
            $display("FAIL sda_fall_pulse: got %0d expected 1", n_fall);
        end
        din = 2'b11;
        for (int t = 0; t < 12; t++) begin
            tick(obs, exp);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL sda_rise_model: got %h expected %h", obs, exp);
            end
        end
    endtask

    task automatic test_glitch();
        logic [7:0] obs, exp;
        int n_gl, n_fall, n_rise;
        cfg_len = 4'd4;
        for (int len = 3; len <= 5; len++) begin
            n_gl = 0;
            n_fall = 0;
            n_rise = 0;
            for (int t = 0; t < len + 14; t++) begin
                din = (t < len) ? 2'b10 : 2'b11;
                tick(obs, exp);
                vectors++;
                if (obs !== exp) begin
                    miscompares++;
                    $display("FAIL scl_pulse_model len=%0d: got %h expected %h", len, obs, exp);
                end
                if (obs[6]) n_gl++;
                if (obs[4]) n_fall++;
                if (obs[2]) n_rise++;
            end
            vectors++;
            if (n_gl != ((len <= 4) ? 1 : 0) || n_fall != ((len <= 4) ? 0 : 1)
                || n_rise != ((len <= 4) ? 0 : 1)) begin
                miscompares++;
                $display("FAIL scl_pulse_counts len=%0d: got glitch=%0d fall=%0d rise=%0d",
                         len, n_gl, n_fall, n_rise);
            end
        end
    endtask

    task automatic test_l0();
        logic [7:0] obs, exp;
        int t_low, n_low, n_gl;
        t_low = -1;
        n_low = 0;
        n_gl = 0;
        cfg_len = 4'd0;
        for (int t = 1; t <= 10; t++) begin
            din = (t == 1) ? 2'b10 : 2'b11;
            tick(obs, exp);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL l0_model: got %h expected %h", obs, exp);
            end
            if (obs[0] == 1'b0) begin
                n_low++;
                if (t_low < 0) t_low = t;
            end
            if (obs[7:6] != 2'b00) n_gl++;
        end
        vectors++;
        if (t_low != SYNC_STG + 1 || n_low != 1 || n_gl != 0) begin
            miscompares++;
            $display("FAIL l0_pass: got at=%0d width=%0d glitch=%0d expected at=%0d width=1 glitch=0",
                     t_low, n_low, n_gl, SYNC_STG + 1);
        end
    endtask

    task automatic test_bypass();
        logic [7:0] obs, exp;
        logic [1:0] hist [64];
        logic [1:0] ed, ep;
        byp = 1'b1;
        cfg_len = 4'd15;
        for (int t = 1; t <= 40; t++) begin
            hist[t] = 2'($urandom_range(0, 3));
            din = hist[t];
            tick(obs, exp);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL bypass_model: got %h expected %h", obs, exp);
            end
            if (t > SYNC_STG + 1) begin
                ed = hist[t-SYNC_STG];
                ep = hist[t-SYNC_STG-1];
                vectors++;
                if (obs !== {2'b00, ep & ~ed, ed & ~ep, ed}) begin
                    miscompares++;
                    $display("FAIL bypass_delay: got %h expected %h", obs,
                             {2'b00, ep & ~ed, ed & ~ep, ed});
                end
            end
        end
        byp = 1'b0;
        cfg_len = 4'd4;
        din = 2'b11;
        for (int t = 0; t < 16; t++) begin
            tick(obs, exp);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL bypass_exit_model: got %h expected %h", obs, exp);
            end
        end
    endtask

    task automatic test_shrink_and_reset();
        logic [7:0] obs, exp;
        cfg_len = 4'd10;
        din = 2'b01;
        for (int t = 1; t <= 10; t++) begin
            tick(obs, exp);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL shrink_model: got %h expected %h", obs, exp);
            end
        end
        vectors++;
        if (obs[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL shrink_hold: got dout1=%b expected 1", obs[1]);
        end
        cfg_len = 4'd3;
        tick(obs, exp);
        vectors++;
        if (obs !== exp || obs[1] !== 1'b0 || obs[5] !== 1'b1) begin
            miscompares++;
            $display("FAIL shrink_accept: got %h expected %h", obs, exp);
        end
        cfg_len = 4'd10;
        din = 2'b11;
        for (int t = 0; t < 6; t++) begin
            tick(obs, exp);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL midrun_model: got %h expected %h", obs, exp);
            end
        end
        rst_n = 1'b0;
        tick(obs, exp);
        vectors++;
        if (obs !== 8'h03 || obs !== exp) begin
            miscompares++;
            $display("FAIL midrun_reset: got %h expected 03", obs);
        end
        rst_n = 1'b1;
        for (int t = 0; t < 14; t++) begin
            tick(obs, exp);
            vectors++;
            if (obs !== exp || obs !== 8'h03) begin
                miscompares++;
                $display("FAIL post_reset_quiet: got %h expected 03", obs);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sda_fall();
        test_glitch();
        test_l0();
        test_bypass();
        test_shrink_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
